// File: rtl/lisnoc_ring_inject_arb.sv
// Ring injection arbiter: merges through-traffic from the upstream ring link with
// local injection, locking per packet and bounding how long local traffic can starve.
module lisnoc_ring_inject_arb #(
    parameter int flit_data_width = 16,
    parameter int flit_type_width = 2,
    parameter int starve_limit    = 4,
    localparam int flit_width     = flit_data_width + flit_type_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [flit_width-1:0] ring_in_flit,
    input  logic                  ring_in_valid,
    output logic                  ring_in_ready,
    input  logic [flit_width-1:0] local_in_flit,
    input  logic                  local_in_valid,
    output logic                  local_in_ready,
    output logic [flit_width-1:0] out_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RING  = 2'b01,
        LOCAL = 2'b10
    } state_t;

    localparam logic [flit_type_width-1:0] T_HDR  = flit_type_width'(2'b01);
    localparam logic [flit_type_width-1:0] T_LAST = flit_type_width'(2'b10);
    localparam logic [3:0]                 LIMIT  = 4'(starve_limit);

    state_t                     state, state_nxt;
    logic [3:0]                 starve_cnt, starve_nxt;
    logic                       starved, sel_local, xfer, pkt_done;
    logic [flit_type_width-1:0] out_type;

    assign starved = (starve_cnt == LIMIT);

    // Ring wins ties in IDLE unless local has waited starve_limit ring packets.
    always_comb begin
        sel_local = 1'b0;
        case (state)
            RING:    sel_local = 1'b0;
            LOCAL:   sel_local = 1'b1;
            default: sel_local = local_in_valid & (~ring_in_valid | starved);
        endcase
    end

    assign out_flit       = sel_local ? local_in_flit : ring_in_flit;
    assign out_valid      = rst & (sel_local ? local_in_valid : ring_in_valid);
    assign ring_in_ready  = rst & ~sel_local & out_ready;
    assign local_in_ready = rst & sel_local & out_ready;
    assign grant          = state;

    assign xfer     = out_valid & out_ready;
    assign out_type = out_flit[flit_width-1 -: flit_type_width];
    // Any non-header flit seen in IDLE is a complete packet on its own.
    assign pkt_done = xfer & ((state == IDLE) ? (out_type != T_HDR) : (out_type == T_LAST));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && out_type == T_HDR) state_nxt = sel_local ? LOCAL : RING;
            default: if (pkt_done) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (pkt_done && sel_local)
            starve_nxt = 4'd0;
        else if (pkt_done && local_in_valid) begin
            if (starve_cnt < LIMIT) starve_nxt = starve_cnt + 4'd1;
        end else if (state == IDLE && !local_in_valid)
            starve_nxt = 4'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

endmodule

// File: tb/tb_lisnoc_ring_inject_arb.sv
// Bench for lisnoc_ring_inject_arb: directed vector table, reset corner case,
// then random packet streams checked against a packet-level reference model.
module tb_lisnoc_ring_inject_arb;

    localparam int DW = 16;
    localparam int TW = 2;
    localparam int FW = DW + TW;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] ring_in_flit, local_in_flit, out_flit;
    logic          ring_in_valid, ring_in_ready, local_in_valid, local_in_ready;
    logic          out_valid, out_ready;
    logic [1:0]    grant;

    lisnoc_ring_inject_arb #(.flit_data_width(DW), .flit_type_width(TW), .starve_limit(SL)) dut (
        .clk(clk), .rst(rst),
        .ring_in_flit(ring_in_flit), .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
        .local_in_flit(local_in_flit), .local_in_valid(local_in_valid), .local_in_ready(local_in_ready),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [1:0] rt;
        logic       lv;
        logic [1:0] lt;
        logic       ordy;
        logic       ov;
        logic       rr;
        logic       lr;
        logic [1:0] g;
        logic       src;   // 0 ring, 1 local
    } vec_t;

    vec_t          vt[$];
    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] ring_q[$];
    logic [FW-1:0] local_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rv, input logic [1:0] rt, input logic lv,
                                input logic [1:0] lt, input logic ordy, input logic ov,
                                input logic rr, input logic lr, input logic [1:0] g,
                                input logic src);
        vec_t v;
        v.rv = rv; v.rt = rt; v.lv = lv; v.lt = lt; v.ordy = ordy;
        v.ov = ov; v.rr = rr; v.lr = lr; v.g = g; v.src = src;
        return v;
    endfunction

    // Well-formed packet: single flit, or header / payloads / last.
    task automatic push_pkt(input bit is_local);
        int            len;
        logic [1:0]    t;
        logic [FW-1:0] f;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
            if (len == 1)          t = 2'b11;
            else if (k == 0)       t = 2'b01;
            else if (k == len - 1) t = 2'b10;
            else                   t = 2'b00;
            f = {t, 16'($urandom)};
            if (is_local) local_q.push_back(f);
            else          ring_q.push_back(f);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ring_in_valid = 1'b0; local_in_valid = 1'b0; out_ready = 1'b0;
        ring_in_flit = '0; local_in_flit = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [FW-1:0] rf, lf, f;
        int            m_lock, m_st, pick, nl;
        logic          e_ov, done;

        // Reset state, with both sources presenting flits.
        rst = 1'b0;
        ring_in_valid = 1'b1; local_in_valid = 1'b1; out_ready = 1'b1;
        ring_in_flit = {2'b01, 16'h1234}; local_in_flit = {2'b01, 16'h5678};
        #12;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_ring_ready", 32'(ring_in_ready), 32'd0);
        chk("reset_local_ready", 32'(local_in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        do_reset();

        //                rv  rt     lv  lt     rdy ov  rr  lr  g      src
        // ring 3-flit packet with local waiting, then local
        vt.push_back(mk(1, 2'b01, 1, 2'b11, 1, 1, 1, 0, 2'b00, 0));
        vt.push_back(mk(1, 2'b00, 1, 2'b11, 1, 1, 1, 0, 2'b01, 0));
        vt.push_back(mk(1, 2'b10, 1, 2'b11, 1, 1, 1, 0, 2'b01, 0));
        vt.push_back(mk(0, 2'b00, 1, 2'b11, 1, 1, 0, 1, 2'b00, 1));
        // stray payload / last in IDLE pass as singles
        vt.push_back(mk(1, 2'b00, 0, 2'b00, 1, 1, 1, 0, 2'b00, 0));
        vt.push_back(mk(1, 2'b10, 0, 2'b00, 1, 1, 1, 0, 2'b00, 0));
        // ring packet with out_ready low for 3 cycles
        vt.push_back(mk(1, 2'b01, 0, 2'b00, 1, 1, 1, 0, 2'b00, 0));
        vt.push_back(mk(1, 2'b00, 1, 2'b01, 0, 1, 0, 0, 2'b01, 0));
        vt.push_back(mk(1, 2'b00, 1, 2'b01, 0, 1, 0, 0, 2'b01, 0));
        vt.push_back(mk(1, 2'b00, 1, 2'b01, 0, 1, 0, 0, 2'b01, 0));
        vt.push_back(mk(1, 2'b00, 1, 2'b01, 1, 1, 1, 0, 2'b01, 0));
        vt.push_back(mk(1, 2'b10, 1, 2'b01, 1, 1, 1, 0, 2'b01, 0));
        // local packet with a 2-cycle bubble while ring waits
        vt.push_back(mk(0, 2'b00, 1, 2'b01, 1, 1, 0, 1, 2'b00, 1));
        vt.push_back(mk(1, 2'b01, 0, 2'b00, 1, 0, 0, 1, 2'b10, 1));
        vt.push_back(mk(1, 2'b01, 0, 2'b00, 1, 0, 0, 1, 2'b10, 1));
        vt.push_back(mk(1, 2'b01, 1, 2'b10, 1, 1, 0, 1, 2'b10, 1));
        vt.push_back(mk(1, 2'b11, 0, 2'b00, 1, 1, 1, 0, 2'b00, 0));
        // starvation: 4 ring singles, then local, then ring again
        for (int k = 0; k < SL; k++)
            vt.push_back(mk(1, 2'b11, 1, 2'b11, 1, 1, 1, 0, 2'b00, 0));
        vt.push_back(mk(1, 2'b11, 1, 2'b11, 1, 1, 0, 1, 2'b00, 1));
        vt.push_back(mk(1, 2'b11, 1, 2'b11, 1, 1, 1, 0, 2'b00, 0));

        foreach (vt[i]) begin
            rf = {vt[i].rt, 16'(16'hA000 + i)};
            lf = {vt[i].lt, 16'(16'hB000 + i)};
            ring_in_flit = rf; local_in_flit = lf;
            ring_in_valid = vt[i].rv; local_in_valid = vt[i].lv; out_ready = vt[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("vec%0d_ring_ready", i), 32'(ring_in_ready), 32'(vt[i].rr));
            chk($sformatf("vec%0d_local_ready", i), 32'(local_in_ready), 32'(vt[i].lr));
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].g));
            if (vt[i].ov)
                chk($sformatf("vec%0d_out_flit", i), 32'(out_flit), 32'(vt[i].src ? lf : rf));
            @(posedge clk); #1;
        end

        // Reset pulse in the middle of a local packet.
        ring_in_valid = 1'b0; local_in_valid = 1'b1; out_ready = 1'b1;
        local_in_flit = {2'b01, 16'hC001};
        @(posedge clk); #1;
        ring_in_valid = 1'b1; ring_in_flit = {2'b01, 16'hD001};
        local_in_flit = {2'b00, 16'hC002};
        @(negedge clk);
        chk("rstmid_grant_locked", 32'(grant), 32'd2);
        chk("rstmid_ring_ready_locked", 32'(ring_in_ready), 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_grant_async", 32'(grant), 32'd0);
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_local_ready", 32'(local_in_ready), 32'd0);
        chk("rstmid_ring_ready", 32'(ring_in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstrel_grant", 32'(grant), 32'd0);
        chk("rstrel_ring_ready", 32'(ring_in_ready), 32'd1);
        chk("rstrel_out_flit", 32'(out_flit), 32'({2'b01, 16'hD001}));
        @(posedge clk); #1;
        chk("rstrel_ring_locked", 32'(grant), 32'd1);

        // Random packet streams against the reference model.
        do_reset();
        m_lock = 0; m_st = 0;
        for (int c = 0; c < 3000; c++) begin
            if (ring_q.size() == 0)  push_pkt(1'b0);
            if (local_q.size() == 0) push_pkt(1'b1);
            ring_in_valid  = ($urandom_range(0, 3) != 0);
            local_in_valid = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 4) != 0);
            ring_in_flit   = ring_q[0];
            local_in_flit  = local_q[0];
            @(negedge clk);
            if (m_lock != 0)                                     pick = m_lock;
            else if (ring_in_valid && (m_st < SL || !local_in_valid)) pick = 1;
            else if (local_in_valid)                             pick = 2;
            else                                                 pick = 0;
            e_ov = (pick == 1) ? ring_in_valid : (pick == 2) ? local_in_valid : 1'b0;
            chk("rnd_grant", 32'(grant), 32'(m_lock));
            chk("rnd_out_valid", 32'(out_valid), 32'(e_ov));
            if (pick != 0) begin
                chk("rnd_ring_ready", 32'(ring_in_ready), 32'(pick == 1 && out_ready));
                chk("rnd_local_ready", 32'(local_in_ready), 32'(pick == 2 && out_ready));
            end
            if (e_ov) chk("rnd_out_flit", 32'(out_flit), 32'(pick == 1 ? ring_q[0] : local_q[0]));
            done = 1'b0;
            nl   = m_lock;
            if (e_ov && out_ready) begin
                f = (pick == 1) ? ring_q.pop_front() : local_q.pop_front();
                if (m_lock == 0) begin
                    if (f[FW-1 -: TW] == 2'b01) nl = pick;
                    else                        done = 1'b1;
                end else if (f[FW-1 -: TW] == 2'b10) begin
                    done = 1'b1;
                    nl   = 0;
                end
            end
            if (done && pick == 2)                 m_st = 0;
            else if (done && local_in_valid)       m_st = (m_st < SL) ? m_st + 1 : SL;
            else if (m_lock == 0 && !local_in_valid) m_st = 0;
            m_lock = nl;
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
